// File: rtl/conv_row_feeder.sv
// conv_row_feeder: packs a raster pixel byte stream into a frame buffer and replays each
// frame as 30 row beats (28 image rows + 2 zero rows). Optional macro: FEEDER_DOUBLE_BUF_EN.
`timescale 1ns/1ps

module conv_row_feeder #(
    parameter int PIX_W    = 8,
    parameter int COLS     = 28,
    parameter int ROWS     = 28,
    parameter int PAD_ROWS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [PIX_W-1:0]      in_data,
    input  logic                  in_sof,
    output logic [COLS*PIX_W-1:0] row_data,
    output logic                  conv_rst,
    output logic                  frame_busy,
    output logic                  frame_done,
    output logic                  sof_err
);

    localparam int ROW_W  = COLS * PIX_W;
    localparam int BEATS  = ROWS + PAD_ROWS;
    localparam int COL_W  = $clog2(COLS);
    localparam int ROW_IW = $clog2(ROWS);
    localparam int BEAT_W = $clog2(BEATS);
`ifdef FEEDER_DOUBLE_BUF_EN
    localparam int NBANK  = 2;
`else
    localparam int NBANK  = 1;
`endif
    localparam int ADDR_W = $clog2(NBANK * ROWS);

    typedef enum logic [0:0] {
        FILL   = 1'b0,
        STREAM = 1'b1
    } state_t;

    // Bank 1 rows live directly above bank 0 rows in the flat buffer.
    function automatic logic [ADDR_W-1:0] mem_addr(input logic bank, input logic [ADDR_W-1:0] row);
        return (bank ? ADDR_W'(ROWS) : {ADDR_W{1'b0}}) + row;
    endfunction

    state_t              state_r;
    state_t              state_next_s;
    logic [BEAT_W-1:0]   beat_r;
    logic [BEAT_W-1:0]   beat_next_s;
    logic [COL_W-1:0]    col_r;
    logic [COL_W-1:0]    col_next_s;
    logic [COL_W-1:0]    wr_col_s;
    logic [ROW_IW-1:0]   row_r;
    logic [ROW_IW-1:0]   row_next_s;
    logic [ROW_IW-1:0]   wr_row_s;
    logic                wr_bank_r;
    logic                wr_bank_next_s;
    logic                rd_bank_r;
    logic                rd_bank_next_s;
    logic [1:0]          full_r;
    logic [1:0]          full_next_s;
    logic [ROW_W-1:0]    mem_r [NBANK*ROWS];

    logic                accept_s;
    logic                at_origin_s;
    logic                at_last_s;
    logic                wr_en_s;
    logic                fill_done_s;
    logic                stream_end_s;
    logic                start_s;

    logic                in_ready_r;
    logic                in_ready_next_s;
    logic [ROW_W-1:0]    row_data_r;
    logic [ROW_W-1:0]    row_data_next_s;
    logic                conv_rst_r;
    logic                conv_rst_next_s;
    logic                frame_busy_r;
    logic                frame_busy_next_s;
    logic                frame_done_r;
    logic                frame_done_next_s;
    logic                sof_err_r;
    logic                sof_err_next_s;

    assign in_ready   = in_ready_r;
    assign row_data   = row_data_r;
    assign conv_rst   = conv_rst_r;
    assign frame_busy = frame_busy_r;
    assign frame_done = frame_done_r;
    assign sof_err    = sof_err_r;

    // Framing rules and fill-position advance for the byte offered this cycle
    always_comb begin
        accept_s       = in_valid & in_ready_r;
        at_origin_s    = (col_r == COL_W'(1'b0)) && (row_r == ROW_IW'(1'b0));
        at_last_s      = (col_r == COL_W'(COLS-1)) && (row_r == ROW_IW'(ROWS-1));
        wr_en_s        = 1'b0;
        wr_col_s       = col_r;
        wr_row_s       = row_r;
        col_next_s     = col_r;
        row_next_s     = row_r;
        sof_err_next_s = 1'b0;
        fill_done_s    = 1'b0;
        if (accept_s) begin
            if (in_sof) begin
                // A stray SOF restarts the fill: this byte becomes pixel (0,0).
                wr_en_s        = 1'b1;
                wr_col_s       = COL_W'(1'b0);
                wr_row_s       = ROW_IW'(1'b0);
                col_next_s     = COL_W'(1'b1);
                row_next_s     = ROW_IW'(1'b0);
                sof_err_next_s = ~at_origin_s;
            end else if (at_origin_s) begin
                sof_err_next_s = 1'b1;
            end else begin
                wr_en_s = 1'b1;
                if (at_last_s) begin
                    col_next_s  = COL_W'(1'b0);
                    row_next_s  = ROW_IW'(1'b0);
                    fill_done_s = 1'b1;
                end else if (col_r == COL_W'(COLS-1)) begin
                    col_next_s = COL_W'(1'b0);
                    row_next_s = row_r + ROW_IW'(1'b1);
                end else begin
                    col_next_s = col_r + COL_W'(1'b1);
                end
            end
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Bank occupancy: a bank is full from fill completion until its stream ends
    always_comb begin
        stream_end_s = (state_r == STREAM) && (beat_r == BEAT_W'(BEATS-1));
        full_next_s  = full_r;
        if (stream_end_s) begin
            full_next_s[rd_bank_r] = 1'b0;
        end else begin
            full_next_s[rd_bank_r] = full_r[rd_bank_r];
        end
        if (fill_done_s) begin
            full_next_s[wr_bank_r] = 1'b1;
        end else begin
            full_next_s[wr_bank_r] = full_next_s[wr_bank_r];
        end
`ifdef FEEDER_DOUBLE_BUF_EN
        wr_bank_next_s = wr_bank_r ^ fill_done_s;
        rd_bank_next_s = rd_bank_r ^ stream_end_s;
`else
        wr_bank_next_s = wr_bank_r;
        rd_bank_next_s = rd_bank_r;
`endif
        start_s = (state_r == FILL) &&
                  (full_r[rd_bank_r] || (fill_done_s && (wr_bank_r == rd_bank_r)));
        in_ready_next_s = ~full_next_s[wr_bank_next_s];
    end

    // Stream FSM next state and beat counter
    always_comb begin
        state_next_s = state_r;
        beat_next_s  = beat_r;
        case (state_r)
            FILL: begin
                if (start_s) begin
                    state_next_s = STREAM;
                    beat_next_s  = BEAT_W'(1'b0);
                end else begin
                    state_next_s = FILL;
                end
            end
            STREAM: begin
                if (stream_end_s) begin
                    state_next_s = FILL;
                    beat_next_s  = BEAT_W'(1'b0);
                end else begin
                    beat_next_s = beat_r + BEAT_W'(1'b1);
                end
            end
            default: begin
                state_next_s = FILL;
                beat_next_s  = BEAT_W'(1'b0);
            end
        endcase
    end

    // Output next values; the buffer row is addressed with the upcoming beat number
    always_comb begin
        row_data_next_s   = {ROW_W{1'b0}};
        conv_rst_next_s   = 1'b1;
        frame_busy_next_s = 1'b0;
        frame_done_next_s = 1'b0;
        case (state_next_s)
            STREAM: begin
                conv_rst_next_s   = 1'b0;
                frame_busy_next_s = 1'b1;
                frame_done_next_s = (beat_next_s == BEAT_W'(BEATS-1));
                if (beat_next_s < BEAT_W'(ROWS)) begin
                    row_data_next_s = mem_r[mem_addr(rd_bank_r, ADDR_W'(beat_next_s))];
                end else begin
                    row_data_next_s = {ROW_W{1'b0}};
                end
            end
            FILL: begin
                conv_rst_next_s = 1'b1;
            end
            default: begin
                conv_rst_next_s = 1'b1;
            end
        endcase
    end

    // Control state, fill position and bank bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= FILL;
            beat_r    <= BEAT_W'(1'b0);
            col_r     <= COL_W'(1'b0);
            row_r     <= ROW_IW'(1'b0);
            wr_bank_r <= 1'b0;
            rd_bank_r <= 1'b0;
            full_r    <= 2'b00;
        end else begin
            state_r   <= state_next_s;
            beat_r    <= beat_next_s;
            col_r     <= col_next_s;
            row_r     <= row_next_s;
            wr_bank_r <= wr_bank_next_s;
            rd_bank_r <= rd_bank_next_s;
            full_r    <= full_next_s;
        end
    end

    // Registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready_r   <= 1'b0;
            row_data_r   <= {ROW_W{1'b0}};
            conv_rst_r   <= 1'b1;
            frame_busy_r <= 1'b0;
            frame_done_r <= 1'b0;
            sof_err_r    <= 1'b0;
        end else begin
            in_ready_r   <= in_ready_next_s;
            row_data_r   <= row_data_next_s;
            conv_rst_r   <= conv_rst_next_s;
            frame_busy_r <= frame_busy_next_s;
            frame_done_r <= frame_done_next_s;
            sof_err_r    <= sof_err_next_s;
        end
    end

    // Frame buffer write port; contents need no reset since the fill position restarts
    always_ff @(posedge clk) begin
        if (wr_en_s && !rst) begin
            mem_r[mem_addr(wr_bank_r, ADDR_W'(wr_row_s))][int'(wr_col_s)*PIX_W +: PIX_W] <= in_data;
        end
    end

endmodule

// File: tb/tb_conv_row_feeder.sv
// Bench for conv_row_feeder: directed frames, a known-answer beat table and randomized
// traffic, all compared every cycle against a queue-based frame model.
`timescale 1ns/1ps

module tb_conv_row_feeder;

    localparam int PIX_W = 8;
    localparam int COLS  = 28;
    localparam int ROWS  = 28;
    localparam int BEATS = 30;
    localparam int NPIX  = COLS * ROWS;
    localparam int ROW_W = COLS * PIX_W;
`ifdef FEEDER_DOUBLE_BUF_EN
    localparam bit DBL = 1'b1;
`else
    localparam bit DBL = 1'b0;
`endif

    typedef logic [NPIX*PIX_W-1:0] frame_t;
    typedef struct {
        int         beat;
        int         col;
        logic [7:0] exp;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_data;
    logic             in_sof;
    logic [ROW_W-1:0] row_data;
    logic             conv_rst;
    logic             frame_busy;
    logic             frame_done;
    logic             sof_err;

    int checks = 0;
    int errors = 0;

    conv_row_feeder dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sof    (in_sof),
        .row_data  (row_data),
        .conv_rst  (conv_rst),
        .frame_busy(frame_busy),
        .frame_done(frame_done),
        .sof_err   (sof_err)
    );

    always #5 clk = ~clk;

    // reference model: completed frames wait in a queue; m_beat = -1 when not streaming
    frame_t m_cur;
    frame_t m_q[$];
    int     m_pos;
    int     m_beat;
    bit     m_ready;
    bit     m_err;
    bit     m_acc;

    int               cyc, first_acc, last_acc, fall_cyc, err_cnt, busy_cnt, notready_busy;
    logic             prev_conv_rst;
    bit               tog;
    logic [ROW_W-1:0] cap [BEATS];
    vec_t             vecs [10];

    function automatic logic [7:0] ref_pix(input int p);
        return 8'(p & 255);
    endfunction

    function automatic logic [ROW_W-1:0] ref_row(input int r);
        logic [ROW_W-1:0] res;
        res = '0;
        for (int c = 0; c < COLS; c++) res[c*8 +: 8] = ref_pix(r*COLS + c);
        return res;
    endfunction

    function automatic logic [ROW_W-1:0] exp_row();
        frame_t f;
        if (m_beat >= 0 && m_beat < ROWS) begin
            f = m_q[0];
            return f[m_beat*ROW_W +: ROW_W];
        end
        return '0;
    endfunction

    task automatic chk(input string name, input logic [ROW_W-1:0] got, input logic [ROW_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, got, exp);
        end
    endtask

    task automatic m_edge();
        if (rst) begin
            m_pos = 0; m_q.delete(); m_beat = -1; m_ready = 1'b0; m_err = 1'b0; m_acc = 1'b0;
        end else begin
            m_acc = in_valid && m_ready;
            m_err = 1'b0;
            if (m_acc) begin
                if (in_sof) begin
                    m_err = (m_pos != 0);
                    m_cur[7:0] = in_data;
                    m_pos = 1;
                end else if (m_pos == 0) begin
                    m_err = 1'b1;
                end else begin
                    m_cur[m_pos*8 +: 8] = in_data;
                    m_pos++;
                    if (m_pos == NPIX) begin
                        m_q.push_back(m_cur);
                        m_pos = 0;
                    end
                end
            end
            if (m_beat == BEATS-1) begin
                m_q.delete(0);
                m_beat = -1;
            end else if (m_beat >= 0) begin
                m_beat++;
            end else if (m_q.size() > 0) begin
                m_beat = 0;
            end
            m_ready = DBL ? (m_q.size() < 2) : (m_q.size() == 0);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        m_edge();
        if (m_acc) begin
            if (first_acc < 0) first_acc = cyc - 1;
            last_acc = cyc - 1;
        end
        #1;
        chk("in_ready",   in_ready,   m_ready);
        chk("conv_rst",   conv_rst,   m_beat < 0);
        chk("frame_busy", frame_busy, m_beat >= 0);
        chk("frame_done", frame_done, m_beat == BEATS-1);
        chk("sof_err",    sof_err,    m_err);
        chk("row_data",   row_data,   exp_row());
        if (m_beat >= 0) cap[m_beat] = row_data;
        if (sof_err === 1'b1) err_cnt++;
        if (frame_busy === 1'b1) busy_cnt++;
        if (frame_busy === 1'b1 && in_ready !== 1'b1) notready_busy++;
        if (conv_rst === 1'b0 && prev_conv_rst === 1'b1 && fall_cyc < 0) fall_cyc = cyc;
        prev_conv_rst = conv_rst;
    endtask

    task automatic clear_meas();
        first_acc = -1; last_acc = -1; fall_cyc = -1;
        err_cnt = 0; busy_cnt = 0; notready_busy = 0;
        for (int k = 0; k < BEATS; k++) cap[k] = '1;
    endtask

    task automatic drive_byte(input logic [7:0] d, input logic s, input bit toggle);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            if (toggle) begin
                in_valid = tog;
                tog = ~tog;
            end else begin
                in_valid = 1'b1;
            end
            in_data = d;
            in_sof  = s;
            tick();
            done = m_acc;
        end
        in_valid = 1'b0;
        in_sof   = 1'b0;
        if (!done) begin
            checks++; errors++;
            $display("FAIL byte_timeout at cycle %0d: got no acceptance expected acceptance", cyc);
        end
    endtask

    task automatic send_frame(input bit toggle);
        for (int p = 0; p < NPIX; p++) drive_byte(ref_pix(p), p == 0, toggle);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_sof   = 1'b0;
        repeat (n) tick();
    endtask

    task automatic check_beats(input string name);
        for (int k = 0; k < BEATS; k++) chk(name, cap[k], (k < ROWS) ? ref_row(k) : '0);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [ROW_W-1:0] t;
        vecs[0] = '{beat: 0,  col: 0,  exp: 8'h00};
        vecs[1] = '{beat: 0,  col: 27, exp: 8'h1B};
        vecs[2] = '{beat: 1,  col: 0,  exp: 8'h1C};
        vecs[3] = '{beat: 9,  col: 3,  exp: 8'hFF};
        vecs[4] = '{beat: 10, col: 0,  exp: 8'h18};
        vecs[5] = '{beat: 13, col: 10, exp: 8'h76};
        vecs[6] = '{beat: 27, col: 0,  exp: 8'hF4};
        vecs[7] = '{beat: 27, col: 27, exp: 8'h0F};
        vecs[8] = '{beat: 28, col: 5,  exp: 8'h00};
        vecs[9] = '{beat: 29, col: 27, exp: 8'h00};

        rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_data = 8'h00; tog = 1'b0;
        cyc = 0; prev_conv_rst = 1'b1;
        m_pos = 0; m_beat = -1; m_ready = 1'b0; m_err = 1'b0; m_acc = 1'b0; m_cur = '0;
        clear_meas();

        // reset values
        repeat (3) tick();
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_conv_rst", conv_rst, 1'b1);
        chk("rst_row_data", row_data, '0);
        chk("rst_busy", frame_busy, 1'b0);
        chk("rst_done", frame_done, 1'b0);
        chk("rst_sof_err", sof_err, 1'b0);
        rst = 1'b0;
        tick();
        chk("ready_after_release", in_ready, 1'b1);

        // reference frame, in_valid always high
        clear_meas();
        send_frame(1'b0);
        idle(40);
        chk("start_latency", fall_cyc, last_acc + 1);
        chk("fill_cycles", last_acc - first_acc, NPIX - 1);
        chk("busy_cycles", busy_cnt, BEATS);
        for (int i = 0; i < 10; i++) begin
            t = cap[vecs[i].beat];
            chk("beat_vec", t[vecs[i].col*8 +: 8], vecs[i].exp);
        end

        // same frame with in_valid toggling
        clear_meas();
        send_frame(1'b1);
        idle(40);
        chk("toggle_latency", fall_cyc, last_acc + 1);
        check_beats("toggle_beat");

        // first byte without SOF is dropped
        clear_meas();
        drive_byte(8'hA5, 1'b0, 1'b0);
        chk("nosof_err_pulse", err_cnt, 1);
        send_frame(1'b0);
        idle(40);
        chk("nosof_err_total", err_cnt, 1);
        check_beats("nosof_beat");

        // SOF at (5,3) discards the partial frame
        clear_meas();
        for (int p = 0; p < 3*COLS + 5; p++) drive_byte(ref_pix(p), p == 0, 1'b0);
        chk("midsof_no_err_yet", err_cnt, 0);
        send_frame(1'b0);
        idle(40);
        chk("midsof_err", err_cnt, 1);
        chk("midsof_latency", fall_cyc, last_acc + 1);
        check_beats("midsof_beat");

        // reset during beat 10 aborts the stream
        clear_meas();
        send_frame(1'b0);
        for (int i = 0; i < 20; i++) begin
            if (m_beat == 10) break;
            tick();
        end
        chk("abort_beat10_row", row_data, ref_row(10));
        rst = 1'b1;
        tick();
        chk("abort_conv_rst", conv_rst, 1'b1);
        chk("abort_row_data", row_data, '0);
        chk("abort_busy", frame_busy, 1'b0);
        rst = 1'b0;
        tick();
        chk("abort_ready", in_ready, 1'b1);
        busy_cnt = 0;
        idle(40);
        chk("abort_no_stream", busy_cnt, 0);

`ifdef FEEDER_DOUBLE_BUF_EN
        // two frames back-to-back into alternating banks
        clear_meas();
        send_frame(1'b0);
        send_frame(1'b0);
        idle(40);
        chk("dbl_ready_in_stream", notready_busy, 0);
        chk("dbl_busy_cycles", busy_cnt, 2*BEATS);
        check_beats("dbl_beat");
`endif

        // randomized traffic with occasional framing errors and resets
        for (int i = 0; i < 6000; i++) begin
            rst      = ($urandom_range(0, 2999) == 0);
            in_valid = ($urandom_range(0, 9) < 7);
            in_data  = 8'($urandom);
            if (m_pos == 0) in_sof = ($urandom_range(0, 9) != 0);
            else            in_sof = ($urandom_range(0, 399) == 0);
            tick();
        end
        rst = 1'b0;
        idle(40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv_row_feeder.md
Name: conv_row_feeder

Overview:
- Front-end producer for the 28x28 3x3 convolution row engine.
- Accepts an 8-bit pixel byte stream on a valid/ready handshake and packs 28 pixels per row into a frame buffer.
- Once a full frame is buffered, it streams exactly 30 row beats (28 image rows, then 2 zero rows) back-to-back on a 224-bit row bus.
- It gates the engine's synchronous reset (conv_rst) so the engine's internal line counter is aligned to row 0 of every frame.

Parameters:
- PIX_W, 8, pixel width in bits.
- COLS, 28, pixels per row; row bus width is COLS*PIX_W = 224.
- ROWS, 28, image rows per frame.
- PAD_ROWS, 2, zero rows appended after the image rows in each stream.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  pixel byte valid.
- in_ready  out  1  feeder can accept a byte this cycle.
- in_data  in  PIX_W  pixel byte, raster order.
- in_sof  in  1  marks pixel (0,0) of a frame; qualified by in_valid.
- row_data  out  COLS*PIX_W  row beat to the engine; pixel c occupies bits [c*8+7:c*8].
- conv_rst  out  1  engine reset; held high except during a stream.
- frame_busy  out  1  high while streaming.
- frame_done  out  1  one-cycle pulse on the last stream beat.
- sof_err  out  1  one-cycle pulse on a framing error.

Behaviour:
- Reset values: in_ready=0, row_data=0, conv_rst=1, frame_busy=0, frame_done=0, sof_err=0, col=0, row=0, state=FILL.
- All outputs are registered. rst asserted mid-stream aborts the frame and discards buffered data. The first cycle after reset release has in_ready=1.
- FILL state:
  - in_ready=1.
  - A byte is accepted when in_valid & in_ready. It is written to buf[row] bits [col*8+7:col*8].
  - col wraps from 27 to 0 with row+1.
- Framing rules:
  - A byte at position (0,0) must carry in_sof. If it does not, the byte is dropped, sof_err pulses, and the position stays (0,0).
  - in_sof on a byte at any position other than (0,0) pulses sof_err, discards the partial frame, and stores the byte as pixel (0,0).
- Acceptance of pixel (27,27) at cycle T:
  - Next state is STREAM and in_ready=0 from T+1.
- STREAM state, beat k=0..29 on cycle T+1+k:
  - conv_rst=0 and frame_busy=1.
  - row_data=buf[k] for k<ROWS and 0 for k>=ROWS.
  - frame_done=1 on k=29 only.
- End of stream at T+31:
  - conv_rst=1, frame_busy=0, row_data=0, state=FILL, in_ready=1.
  - This gives a guaranteed minimum of one cycle with conv_rst=1 between consecutive streams.
- Stream length is fixed at ROWS+PAD_ROWS=30 beats. It is never shortened or stalled; the engine has no backpressure.
- A beat counter (5 bits) counts 0..29 and clears on entry to STREAM.
- The frame buffer is ROWS x 224 bits, addressed by row. Reads are registered, so the address is driven one cycle ahead of the beat.
- in_valid while in_ready=0 has no effect. A byte is not consumed unless in_ready=1 in that cycle.
- in_sof without in_valid is ignored.

Optional Feature:
- Macro: FEEDER_DOUBLE_BUF_EN.
- When defined:
  - Two frame banks; FILL writes bank w while STREAM reads bank r.
  - in_ready stays 1 during STREAM unless both banks hold complete unstreamed frames.
  - A completed frame is queued. Its stream starts on the cycle after the preceding stream's conv_rst=1 gap cycle (one gap cycle minimum). Banks alternate.
  - sof_err recovery affects only the fill bank.
- When undefined:
  - Single bank.
  - in_ready=0 from T+1 through T+30 as described in Behaviour.

Test Plan:
- Reset then frame with pixel(c,r)=(r*28+c)&0xFF, in_valid always high → 784 bytes accepted in 784 cycles. conv_rst falls the cycle after the last byte. Beat 0 row_data[7:0]=0x00 and [223:216]=0x1B. Beat 27 [7:0]=0xF4. Beats 28-29 are 0. frame_done on beat 29. conv_rst=1 after.
- Same frame with in_valid toggling 1/0 → identical row beats. Stream starts exactly one cycle after the 784th accepted byte.
- First byte without in_sof → sof_err pulse and byte dropped. The following in_sof byte becomes (0,0), and the stream matches the reference frame.
- in_sof asserted at position (5,3) → sof_err pulse, partial frame discarded, and a full frame of 784 bytes is then required before conv_rst falls.
- rst asserted at stream beat 10 → next cycle conv_rst=1, row_data=0, frame_busy=0, in_ready=1. A new frame is required before the next stream.
- FEEDER_DOUBLE_BUF_EN: two frames sent back-to-back with in_valid high:
  - in_ready stays 1 during the first stream.
  - Second stream begins after exactly one conv_rst=1 gap cycle if its fill completes earlier; otherwise on the cycle after its last byte.
